// File: rtl/alu_btn_ctrl_pkg.sv
// Shared constants for the button-driven ALU: opcodes, flag bit positions
// and the default debounce length.
package alu_btn_ctrl_pkg;

  localparam int DEBOUNCE_CNT_DEF = 4;

  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_XOR = 6'b100110;
  localparam logic [5:0] OP_NOR = 6'b100111;
  localparam logic [5:0] OP_SRL = 6'b000010;
  localparam logic [5:0] OP_SRA = 6'b000011;

  localparam int FLAG_ZERO  = 0;
  localparam int FLAG_NEG   = 1;
  localparam int FLAG_CARRY = 2;
  localparam int FLAG_OVF   = 3;

endpackage

// File: rtl/alu_btn_ctrl_btn_debounce.sv
// Two-flop synchroniser, counter debouncer and rising-edge detect for one
// raw push button. rise pulses in the cycle the accepted level goes 0->1.
module btn_debounce
  import alu_btn_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CNT = DEBOUNCE_CNT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic rise
);

  localparam int CW = $clog2(DEBOUNCE_CNT) + 1;

  logic          sync1;
  logic          sync2;
  logic          level;
  logic [CW-1:0] cnt;
  logic          settle;

  assign settle = (sync2 != level) && (cnt == CW'(DEBOUNCE_CNT - 1));
  assign rise   = settle && sync2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (settle) begin
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_btn_ctrl.sv
// Switch/button driven ALU: buttons latch operands and opcode from the
// switches, the result and flags are registered while i_valid is high.
module alu_btn_ctrl
  import alu_btn_ctrl_pkg::*;
#(
  parameter int NB_DATA      = 8,
  parameter int NB_OP        = 6,
  parameter int DEBOUNCE_CNT = DEBOUNCE_CNT_DEF
) (
  input  logic               clk,
  input  logic               i_rst,
  input  logic               i_valid,
  input  logic [NB_DATA-1:0] i_sw_data,
  input  logic [2:0]         i_btn,
  output logic [NB_DATA-1:0] o_led,
  output logic [3:0]         o_flags,
  output logic [2:0]         o_loaded
);

  localparam int MSB = NB_DATA - 1;

  logic [2:0]         rise;
  logic [NB_DATA-1:0] reg_a;
  logic [NB_DATA-1:0] reg_b;
  logic [NB_OP-1:0]   reg_op;
  logic [NB_DATA:0]   sum;
  logic [NB_DATA:0]   diff;
  logic               big_shift;
  logic [NB_DATA-1:0] result;
  logic               carry;
  logic               ovf;
  logic [3:0]         flags;

  for (genvar i = 0; i < 3; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CNT(DEBOUNCE_CNT)
    ) u_btn_debounce (
      .clk (clk),
      .rst (i_rst),
      .btn (i_btn[i]),
      .rise(rise[i])
    );
  end

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      reg_a    <= '0;
      reg_b    <= '0;
      reg_op   <= '0;
      o_loaded <= '0;
    end else begin
      if (rise[0]) reg_a  <= i_sw_data;
      if (rise[1]) reg_b  <= i_sw_data;
      if (rise[2]) reg_op <= i_sw_data[NB_OP-1:0];
      o_loaded <= o_loaded | rise;
    end
  end

  // The extra top bit of sum/diff is the unsigned carry-out / borrow.
  assign sum       = {1'b0, reg_a} + {1'b0, reg_b};
  assign diff      = {1'b0, reg_a} - {1'b0, reg_b};
  assign big_shift = (reg_b >= NB_DATA'(NB_DATA));

  always_comb begin
    result = '0;
    carry  = 1'b0;
    ovf    = 1'b0;
    case (reg_op)
      NB_OP'(OP_ADD): begin
        result = sum[NB_DATA-1:0];
        carry  = sum[NB_DATA];
        ovf    = (reg_a[MSB] == reg_b[MSB]) && (result[MSB] != reg_a[MSB]);
      end
      NB_OP'(OP_SUB): begin
        result = diff[NB_DATA-1:0];
        carry  = diff[NB_DATA];
        ovf    = (reg_a[MSB] != reg_b[MSB]) && (result[MSB] != reg_a[MSB]);
      end
      NB_OP'(OP_AND): result = reg_a & reg_b;
      NB_OP'(OP_OR):  result = reg_a | reg_b;
      NB_OP'(OP_XOR): result = reg_a ^ reg_b;
      NB_OP'(OP_NOR): result = ~(reg_a | reg_b);
      NB_OP'(OP_SRL): result = big_shift ? '0 : (reg_a >> reg_b);
      NB_OP'(OP_SRA): result = big_shift ? {NB_DATA{reg_a[MSB]}}
                                         : $unsigned($signed(reg_a) >>> reg_b);
      default:        result = '0;
    endcase
  end

  always_comb begin
    flags             = '0;
    flags[FLAG_ZERO]  = (result == '0);
    flags[FLAG_NEG]   = result[MSB];
    flags[FLAG_CARRY] = carry;
    flags[FLAG_OVF]   = ovf;
  end

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      o_led   <= '0;
      o_flags <= '0;
    end else if (i_valid) begin
      o_led   <= result;
      o_flags <= flags;
    end
  end

endmodule
